// File: rtl/aes_pkg.sv
// Shared types and GF(2^8) helpers for the iterative AES cipher core.
// Byte n of a block sits at bits [8*(15-n) +: 8]; byte n = s[n%4, n/4].
package aes_pkg;

  typedef enum logic [1:0] {IDLE, KEXP, RND0, RND} state_t;

  localparam int NWORDS = 60;

  function automatic logic [3:0] nr_of(input logic [3:0] nk);
    case (nk)
      4'd6:    return 4'd12;
      4'd8:    return 4'd14;
      default: return 4'd10;
    endcase
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = 8'h00;
    x = a;
    y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = xtime(x);
      y = {1'b0, y[7:1]};
    end
    return p;
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] i);
    case (i)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  function automatic int byte_idx(input int r, input int c);
    return 4 * c + r;
  endfunction

  function automatic logic [7:0] get_byte(input logic [127:0] blk, input int n);
    return blk[8*(15-n) +: 8];
  endfunction

  function automatic logic [31:0] mix_col(input logic [31:0] col);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = col;
    return {gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3,
            a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3,
            a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03),
            gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02)};
  endfunction

  function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = col;
    return {gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09),
            gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d),
            gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b),
            gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e)};
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// Combinational AES S-box, forward or inverse, built from the GF(2^8) inverse
// (x^254, which maps 0 to 0 for free) plus the affine transform.
module aes_sbox
  import aes_pkg::*;
(
  input  logic       inv,
  input  logic [7:0] din,
  output logic [7:0] dout
);

  function automatic logic [7:0] rotl(input logic [7:0] v, input int n);
    return (v << n) | (v >> (8 - n));
  endfunction

  function automatic logic [7:0] ginv(input logic [7:0] x);
    logic [7:0] x2, x4, x8, x16, x32, x64, x128;
    x2   = gmul(x, x);
    x4   = gmul(x2, x2);
    x8   = gmul(x4, x4);
    x16  = gmul(x8, x8);
    x32  = gmul(x16, x16);
    x64  = gmul(x32, x32);
    x128 = gmul(x64, x64);
    return gmul(gmul(gmul(x2, x4), gmul(x8, x16)), gmul(gmul(x32, x64), x128));
  endfunction

  logic [7:0] t;

  always_comb begin
    t    = 8'h00;
    dout = 8'h00;
    if (inv) begin
      t    = rotl(din, 1) ^ rotl(din, 3) ^ rotl(din, 6) ^ 8'h05;
      dout = ginv(t);
    end else begin
      t    = ginv(din);
      dout = t ^ rotl(t, 1) ^ rotl(t, 2) ^ rotl(t, 3) ^ rotl(t, 4) ^ 8'h63;
    end
  end

endmodule

// File: rtl/aes_cipher.sv
// Iterative AES-128/192/256 core: expands the key one word per cycle, then
// runs one full round per cycle in either the forward or straight inverse cipher.
module aes_cipher
  import aes_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic         decrypt,
  input  logic [3:0]   nk,
  input  logic [255:0] key,
  input  logic [127:0] data_in,
  output logic [127:0] data_out,
  output logic         busy,
  output logic         done
);

  state_t state, nextState;

  logic [31:0]  w [0:NWORDS-1];
  logic [127:0] st;
  logic         decQ;
  logic [3:0]   nkQ, nrQ, rci, rnd;
  logic [5:0]   ki;
  logic [2:0]   kmod;

  logic [3:0]   nkNorm;
  logic [5:0]   kEnd;
  logic         lastRound;

  assign nkNorm    = (nk == 4'd6 || nk == 4'd8) ? nk : 4'd4;
  assign kEnd      = {nrQ, 2'b00} + 6'd3;
  assign lastRound = (rnd == nrQ);
  assign busy      = (state != IDLE);

  // Key path: kmod tracks i%nk and rci tracks i/nk so no divider is needed.
  logic [31:0] prevWord, oldWord, rotWord, subWord, tempWord, newWord;

  assign prevWord = w[ki - 6'd1];
  assign oldWord  = w[ki - {2'b00, nkQ}];
  assign rotWord  = (kmod == 3'd0) ? {prevWord[23:0], prevWord[31:24]} : prevWord;

  for (genvar n = 0; n < 4; n++) begin : gKeySbox
    aes_sbox uSbox (.inv(1'b0), .din(rotWord[8*n +: 8]), .dout(subWord[8*n +: 8]));
  end

  always_comb begin
    tempWord = prevWord;
    if (kmod == 3'd0)
      tempWord = subWord ^ {rcon(rci), 24'h000000};
    else if (nkQ == 4'd8 && kmod == 3'd4)
      tempWord = subWord;
    newWord = tempWord ^ oldWord;
  end

  // Round key selection: decrypt walks the schedule backwards from Nr.
  logic [3:0]   rkBase;
  logic [5:0]   rkWord;
  logic [127:0] roundKey;

  assign rkBase   = decQ ? (nrQ - rnd) : rnd;
  assign rkWord   = {rkBase, 2'b00};
  assign roundKey = {w[rkWord], w[rkWord + 6'd1], w[rkWord + 6'd2], w[rkWord + 6'd3]};

  // SubBytes and ShiftRows commute, so both directions substitute first.
  logic [127:0] subState, shifted, mixed, ark, roundOut;

  for (genvar n = 0; n < 16; n++) begin : gStateSbox
    aes_sbox uSbox (.inv(decQ), .din(st[8*n +: 8]), .dout(subState[8*n +: 8]));
  end

  always_comb begin
    shifted = '0;
    mixed   = '0;
    ark     = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        shifted[8*(15-byte_idx(r, c)) +: 8] =
          get_byte(subState, byte_idx(r, decQ ? (c - r + 4) % 4 : (c + r) % 4));
      end
    end
    if (decQ) begin
      ark = shifted ^ roundKey;
      for (int c = 0; c < 4; c++)
        mixed[32*(3-c) +: 32] = lastRound ? ark[32*(3-c) +: 32] : inv_mix_col(ark[32*(3-c) +: 32]);
      roundOut = mixed;
    end else begin
      for (int c = 0; c < 4; c++)
        mixed[32*(3-c) +: 32] = lastRound ? shifted[32*(3-c) +: 32] : mix_col(shifted[32*(3-c) +: 32]);
      roundOut = mixed ^ roundKey;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= nextState;
  end

  always_comb begin
    nextState = state;
    case (state)
      IDLE: if (start) nextState = KEXP;
      KEXP: if (ki == kEnd) nextState = RND0;
      RND0: nextState = RND;
      RND:  if (lastRound) nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  // The schedule is never reset; it is fully rewritten before every use.
  always_ff @(posedge clk) begin
    if (state == IDLE && start) begin
      for (int j = 0; j < 8; j++)
        if (j < int'(nkNorm)) w[j] <= key[32*(int'(nkNorm) - 1 - j) +: 32];
    end else if (state == KEXP) begin
      w[ki] <= newWord;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st       <= '0;
      decQ     <= 1'b0;
      nkQ      <= 4'd4;
      nrQ      <= 4'd10;
      ki       <= '0;
      kmod     <= '0;
      rci      <= 4'd1;
      rnd      <= '0;
      data_out <= '0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          st   <= data_in;
          decQ <= decrypt;
          nkQ  <= nkNorm;
          nrQ  <= nr_of(nkNorm);
          ki   <= {2'b00, nkNorm};
          kmod <= 3'd0;
          rci  <= 4'd1;
          rnd  <= 4'd0;
        end
        KEXP: begin
          ki <= ki + 6'd1;
          if ({1'b0, kmod} == nkQ - 4'd1) begin
            kmod <= 3'd0;
            rci  <= rci + 4'd1;
          end else begin
            kmod <= kmod + 3'd1;
          end
        end
        RND0: begin
          st  <= st ^ roundKey;
          rnd <= 4'd1;
        end
        RND: begin
          st <= roundOut;
          if (lastRound) begin
            data_out <= roundOut;
            done     <= 1'b1;
          end else begin
            rnd <= rnd + 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_cipher.sv
// Directed-vector bench for aes_cipher: FIPS-197 / SP800-38A vectors,
// round trips, latency, ignored start while busy and mid-operation reset.
module tb_aes_cipher;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic         decrypt;
  logic [3:0]   nk;
  logic [255:0] key;
  logic [127:0] data_in;
  logic [127:0] data_out;
  logic         busy;
  logic         done;

  int errorCount = 0;
  int checkCount = 0;

  localparam logic [255:0] K128 = {128'h0, 128'h000102030405060708090a0b0c0d0e0f};
  localparam logic [255:0] K192 = {64'h0, 192'h000102030405060708090a0b0c0d0e0f1011121314151617};
  localparam logic [255:0] K256 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [255:0] KSP  = {128'h0, 128'h2b7e151628aed2a6abf7158809cf4f3c};
  localparam logic [127:0] PT     = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT128  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] CT192  = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
  localparam logic [127:0] CT256  = 128'h8ea2b7ca516745bfeafc49904b496089;
  localparam logic [127:0] PTSP   = 128'h6bc1bee22e409f96e93d7e117393172a;
  localparam logic [127:0] CTSP   = 128'h3ad77bb40d7a3660a89ecaf32466ef97;
  localparam logic [127:0] PTA    = 128'h00112233445566778899aabbccddeebb;
  localparam logic [127:0] PTB    = 128'h00112233445566778899aabbccddeeee;

  aes_cipher dut (
    .clk(clk), .reset(reset), .start(start), .decrypt(decrypt), .nk(nk),
    .key(key), .data_in(data_in), .data_out(data_out), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [127:0] actual, input logic [127:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
    end
  endtask

  // One full operation; optionally pulses a bogus start after injectAt cycles.
  task automatic applyStimulus(input logic dec, input logic [3:0] nkv, input logic [255:0] k,
                               input logic [127:0] d, input int injectAt,
                               output logic [127:0] res, output int lat);
    @(negedge clk);
    decrypt = dec;
    nk      = nkv;
    key     = k;
    data_in = d;
    start   = 1'b1;
    @(posedge clk);
    #1;
    start   = 1'b0;
    decrypt = ~dec;
    key     = ~k;
    data_in = ~d;
    nk      = 4'd6;
    checkOutput("busy_after_start", {127'h0, busy}, 128'h1);
    lat = 0;
    while (!done && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
      start = (lat == injectAt);
    end
    start = 1'b0;
    checkOutput("done_seen", {127'h0, done}, 128'h1);
    checkOutput("busy_clear_at_done", {127'h0, busy}, 128'h0);
    res = data_out;
    @(posedge clk);
    #1;
    checkOutput("done_one_cycle", {127'h0, done}, 128'h0);
  endtask

  logic [127:0] res, ctA, ctB;
  int           lat;
  logic         sawDone;

  initial begin
    reset   = 1'b1;
    start   = 1'b0;
    decrypt = 1'b0;
    nk      = 4'd4;
    key     = '0;
    data_in = '0;
    #12;
    checkOutput("reset_busy", {127'h0, busy}, 128'h0);
    checkOutput("reset_done", {127'h0, done}, 128'h0);
    checkOutput("reset_data_out", data_out, 128'h0);
    @(negedge clk);
    reset = 1'b0;

    applyStimulus(1'b0, 4'd4, K128, PT, 0, res, lat);
    checkOutput("enc128", res, CT128);
    checkOutput("lat128", 128'(lat), 128'd51);
    applyStimulus(1'b0, 4'd6, K192, PT, 0, res, lat);
    checkOutput("enc192", res, CT192);
    checkOutput("lat192", 128'(lat), 128'd59);
    applyStimulus(1'b0, 4'd8, K256, PT, 0, res, lat);
    checkOutput("enc256", res, CT256);
    checkOutput("lat256", 128'(lat), 128'd67);

    applyStimulus(1'b0, 4'd4, KSP, PTSP, 0, res, lat);
    checkOutput("enc_sp800", res, CTSP);
    applyStimulus(1'b1, 4'd4, KSP, CTSP, 0, res, lat);
    checkOutput("dec_sp800", res, PTSP);

    applyStimulus(1'b1, 4'd4, K128, CT128, 0, res, lat);
    checkOutput("dec128", res, PT);
    checkOutput("dec_lat128", 128'(lat), 128'd51);
    applyStimulus(1'b1, 4'd6, K192, CT192, 0, res, lat);
    checkOutput("dec192", res, PT);
    applyStimulus(1'b1, 4'd8, K256, CT256, 0, res, lat);
    checkOutput("dec256", res, PT);

    applyStimulus(1'b0, 4'd4, K128, PTA, 0, ctA, lat);
    applyStimulus(1'b1, 4'd4, K128, ctA, 0, res, lat);
    checkOutput("roundtrip_a", res, PTA);
    applyStimulus(1'b0, 4'd4, K128, PTB, 0, ctB, lat);
    applyStimulus(1'b1, 4'd4, K128, ctB, 0, res, lat);
    checkOutput("roundtrip_b", res, PTB);
    checkOutput("ct_differ", {127'h0, ctA != ctB}, 128'h1);

    applyStimulus(1'b0, 4'd5, K128, PT, 0, res, lat);
    checkOutput("nk5_as_128", res, CT128);
    checkOutput("nk5_lat", 128'(lat), 128'd51);

    applyStimulus(1'b0, 4'd4, K128, PT, 10, res, lat);
    checkOutput("start_busy_ignored", res, CT128);
    checkOutput("start_busy_lat", 128'(lat), 128'd51);

    // Abort an AES-256 encrypt twenty cycles in.
    @(negedge clk);
    decrypt = 1'b0;
    nk      = 4'd8;
    key     = K256;
    data_in = PT;
    start   = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    checkOutput("abort_busy", {127'h0, busy}, 128'h0);
    checkOutput("abort_done", {127'h0, done}, 128'h0);
    checkOutput("abort_data_out", data_out, 128'h0);
    @(negedge clk);
    reset   = 1'b0;
    sawDone = 1'b0;
    repeat (70) begin
      @(posedge clk);
      #1;
      if (done) sawDone = 1'b1;
    end
    checkOutput("abort_no_done", {127'h0, sawDone}, 128'h0);

    applyStimulus(1'b0, 4'd8, K256, PT, 0, res, lat);
    checkOutput("after_reset_enc256", res, CT256);
    checkOutput("after_reset_lat", 128'(lat), 128'd67);

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule
